// File: rtl/layer_fetch_sequencer_pkg.sv
// Shared constants, state encoding and the lane-offset helper for the
// layer fetch sequencer.
package layer_fetch_sequencer_pkg;

  localparam int N_LANES    = 10;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int CNT_W      = 16;
  localparam int LANE_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  // k * n by shift-add over the bits of the lane index; with a constant
  // lane index this folds down to a few adders, so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] lane_offset(input logic [LANE_IDX_W-1:0] lane,
                                                    input logic [CNT_W-1:0]      n);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < LANE_IDX_W; i++) begin
      if (lane[i]) begin
        acc = acc + (ADDR_W'(n) << i);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/layer_fetch_sequencer_fetch_addr_lane.sv
// One address lane: loadable incrementer that wraps modulo 2^ADDR_W.
module fetch_addr_lane
  import layer_fetch_sequencer_pkg::*;
(
  input  logic              clock_mem,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  // Load wins over increment; otherwise step by one on every issued read.
  always_ff @(posedge clock_mem or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_value;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/layer_fetch_sequencer.sv
// Read initiator for one 10-neuron tile of a fully connected layer.
// The memory's held output registers are the only storage for the beat in
// flight, so a new read is issued only when that beat is absent or being
// consumed in the same cycle.
module layer_fetch_sequencer
  import layer_fetch_sequencer_pkg::*;
(
  input  logic                      clock_mem,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         x_base,
  input  logic [ADDR_W-1:0]         w_base,
  input  logic [ADDR_W-1:0]         b_base,
  input  logic [CNT_W-1:0]          n_inputs,
  input  logic                      acc_ready,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         x_addr,
  output logic [N_LANES*ADDR_W-1:0] w_addr,
  output logic [N_LANES*ADDR_W-1:0] b_addr,
  output logic                      out_valid,
  output logic                      out_first,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  state_t           state;
  logic [CNT_W-1:0] n_reg;
  logic [CNT_W-1:0] beat;
  logic             load;
  logic             consume;
  logic             last_issue;

  assign load       = (state == IDLE) && start;
  assign mem_rd_en  = (state == ISSUE) && (!out_valid || acc_ready);
  assign consume    = out_valid && acc_ready;
  assign last_issue = (beat == n_reg - CNT_W'(1));

  fetch_addr_lane u_x_lane (
    .clock_mem  (clock_mem),
    .rst        (rst),
    .load       (load),
    .load_value (x_base),
    .inc        (mem_rd_en),
    .addr       (x_addr)
  );

  for (genvar k = 0; k < N_LANES; k++) begin : g_w_lane
    fetch_addr_lane u_w_lane (
      .clock_mem  (clock_mem),
      .rst        (rst),
      .load       (load),
      .load_value (w_base + lane_offset(LANE_IDX_W'(k), n_inputs)),
      .inc        (mem_rd_en),
      .addr       (w_addr[k*ADDR_W +: ADDR_W])
    );
  end

  // Tile sequencing: capture at start, issue beats, wait for the last beat
  // to be consumed, then pulse done for one cycle.
  always_ff @(posedge clock_mem or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n_reg     <= '0;
      beat      <= '0;
      b_addr    <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_reg     <= n_inputs;
            beat      <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            for (int k = 0; k < N_LANES; k++) begin
              b_addr[k*ADDR_W +: ADDR_W] <= b_base + ADDR_W'(k);
            end
            state <= (n_inputs == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (mem_rd_en) begin
            beat      <= beat + CNT_W'(1);
            out_valid <= 1'b1;
            out_first <= (beat == '0);
            out_last  <= last_issue;
            if (last_issue) begin
              state <= DRAIN;
            end
          end else if (consume) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        DRAIN: begin
          if (consume) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_fetch_sequencer.sv
// Testbench for layer_fetch_sequencer. A memory model returns each address
// as its data one cycle after a read, and every consumed beat is compared
// against the tile's expected beat list computed from the address rules.
module tb_layer_fetch_sequencer;

  localparam int NL = 10;
  localparam int AW = 16;

  logic              clock_mem = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     x_base;
  logic [AW-1:0]     w_base;
  logic [AW-1:0]     b_base;
  logic [AW-1:0]     n_inputs;
  logic              acc_ready;
  logic              mem_rd_en;
  logic [AW-1:0]     x_addr;
  logic [NL*AW-1:0]  w_addr;
  logic [NL*AW-1:0]  b_addr;
  logic              out_valid;
  logic              out_first;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [AW-1:0]     mem_x;
  logic [NL*AW-1:0]  mem_w;

  int tests_run    = 0;
  int tests_failed = 0;

  layer_fetch_sequencer dut (
    .clock_mem (clock_mem),
    .rst       (rst),
    .start     (start),
    .x_base    (x_base),
    .w_base    (w_base),
    .b_base    (b_base),
    .n_inputs  (n_inputs),
    .acc_ready (acc_ready),
    .mem_rd_en (mem_rd_en),
    .x_addr    (x_addr),
    .w_addr    (w_addr),
    .b_addr    (b_addr),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock_mem = ~clock_mem;

  // Memory with one-cycle read latency that holds its outputs when idle.
  always @(posedge clock_mem) begin
    if (mem_rd_en === 1'b1) begin
      mem_x <= x_addr;
      mem_w <= w_addr;
    end
  end

  function automatic logic [NL*AW-1:0] build_w(input logic [AW-1:0] wb, input logic [AW-1:0] n,
                                               input int j);
    logic [NL*AW-1:0] v;
    for (int k = 0; k < NL; k++) begin
      v[k*AW +: AW] = 16'(int'(wb) + k * int'(n) + j);
    end
    return v;
  endfunction

  function automatic logic [NL*AW-1:0] build_b(input logic [AW-1:0] bb);
    logic [NL*AW-1:0] v;
    for (int k = 0; k < NL; k++) begin
      v[k*AW +: AW] = 16'(int'(bb) + k);
    end
    return v;
  endfunction

  // mode 0: acc_ready always 1; mode 1: random acc_ready; mode 2: 3-cycle stall mid-stream.
  task automatic run_tile(input logic [AW-1:0] xb, input logic [AW-1:0] wb,
                          input logic [AW-1:0] bb, input logic [AW-1:0] n,
                          input int mode, input bit spam, input string name);
    int            c;
    int            issued;
    int            consumed;
    int            last_c;
    int            stall_left;
    int            budget;
    int            exp_c;
    bit            stalled_once;
    bit            prev_stall;
    bit            finished;
    logic          exp_bit;
    logic [AW-1:0] exp_x;
    logic [AW-1:0] prev_x;
    logic [AW-1:0] prev_mx;
    logic          prev_first;
    logic          prev_last;
    logic [NL*AW-1:0] exp_v;

    @(negedge clock_mem);
    x_base    = xb;
    w_base    = wb;
    b_base    = bb;
    n_inputs  = n;
    start     = 1'b1;
    acc_ready = 1'b1;
    issued = 0; consumed = 0; last_c = 0; stall_left = 0;
    stalled_once = 1'b0; prev_stall = 1'b0; finished = 1'b0;
    prev_x = '0; prev_mx = '0; prev_first = 1'b0; prev_last = 1'b0;
    c = 0;
    budget = 4 * int'(n) + 40;

    while (!finished && c < budget) begin
      @(negedge clock_mem);
      c++;
      if (spam && busy) begin
        start    = 1'($urandom_range(0, 1));
        x_base   = 16'($urandom);
        w_base   = 16'($urandom);
        b_base   = 16'($urandom);
        n_inputs = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      if (mode == 1) begin
        acc_ready = ($urandom_range(0, 3) != 0);
      end else if (mode == 2) begin
        if (issued == 2 && !stalled_once) begin
          stall_left   = 3;
          stalled_once = 1'b1;
        end
        acc_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        acc_ready = 1'b1;
      end
      #1;

      tests_run++;
      exp_v = build_b(bb);
      if (b_addr !== exp_v)
        $display("[TB] FAIL %s b_addr c=%0d: got %h expected %h", name, c, b_addr, exp_v);
      if (b_addr !== exp_v) tests_failed++;

      if (mode == 0) begin
        tests_run++;
        exp_bit = (c >= 1) && (c <= int'(n));
        if (mem_rd_en !== exp_bit) begin
          tests_failed++;
          $display("[TB] FAIL %s rd_en schedule c=%0d: got %b expected %b", name, c, mem_rd_en, exp_bit);
        end
      end

      if (out_valid === 1'b1 && acc_ready === 1'b0) begin
        tests_run++;
        if (mem_rd_en !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL %s rd_en during stall c=%0d: got %b expected 0", name, c, mem_rd_en);
        end
      end

      if (prev_stall) begin
        tests_run++;
        if (x_addr !== prev_x || out_valid !== 1'b1 || out_first !== prev_first ||
            out_last !== prev_last || mem_x !== prev_mx) begin
          tests_failed++;
          $display("[TB] FAIL %s frozen c=%0d: got x=%h v=%b f=%b l=%b d=%h expected x=%h v=1 f=%b l=%b d=%h",
                   name, c, x_addr, out_valid, out_first, out_last, mem_x,
                   prev_x, prev_first, prev_last, prev_mx);
        end
      end

      tests_run++;
      exp_bit = !(done === 1'b1);
      if (busy !== exp_bit) begin
        tests_failed++;
        $display("[TB] FAIL %s busy c=%0d: got %b expected %b", name, c, busy, exp_bit);
      end

      if (mem_rd_en === 1'b1) begin
        tests_run++;
        exp_x = xb + 16'(issued);
        exp_v = build_w(wb, n, issued);
        if (issued >= int'(n) || x_addr !== exp_x || w_addr !== exp_v) begin
          tests_failed++;
          $display("[TB] FAIL %s issue %0d: got x=%h w=%h expected x=%h w=%h (n=%0d)",
                   name, issued, x_addr, w_addr, exp_x, exp_v, n);
        end
        issued++;
      end

      if (out_valid === 1'b1 && acc_ready === 1'b1) begin
        tests_run++;
        exp_x = xb + 16'(consumed);
        exp_v = build_w(wb, n, consumed);
        if (consumed >= int'(n) || mem_x !== exp_x || mem_w !== exp_v ||
            out_first !== (consumed == 0) || out_last !== (consumed == int'(n) - 1)) begin
          tests_failed++;
          $display("[TB] FAIL %s beat %0d: got x=%h w=%h f=%b l=%b expected x=%h w=%h f=%b l=%b",
                   name, consumed, mem_x, mem_w, out_first, out_last, exp_x, exp_v,
                   (consumed == 0), (consumed == int'(n) - 1));
        end
        consumed++;
        last_c = c;
      end

      if (done === 1'b1) begin
        tests_run++;
        exp_c = (n == 0) ? 2 : last_c + 2;
        if (c != exp_c || consumed != int'(n)) begin
          tests_failed++;
          $display("[TB] FAIL %s done timing: got cycle %0d after %0d beats expected cycle %0d after %0d beats",
                   name, c, consumed, exp_c, n);
        end
        finished = 1'b1;
      end

      prev_stall = (out_valid === 1'b1) && (acc_ready === 1'b0);
      prev_x     = x_addr;
      prev_mx    = mem_x;
      prev_first = out_first;
      prev_last  = out_last;
    end

    start = 1'b0;
    tests_run++;
    if (!finished) begin
      tests_failed++;
      $display("[TB] FAIL %s timeout: got no done in %0d cycles expected done", name, budget);
    end
    @(negedge clock_mem);
    #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || issued != int'(n) || consumed != int'(n)) begin
      tests_failed++;
      $display("[TB] FAIL %s wrap-up: got done=%b busy=%b issued=%0d consumed=%0d expected 0 0 %0d %0d",
               name, done, busy, issued, consumed, n, n);
    end
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if (mem_rd_en !== 1'b0 || out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || x_addr !== '0 || w_addr !== '0 || b_addr !== '0) begin
      tests_failed++;
      $display("[TB] FAIL %s: got rd=%b v=%b f=%b l=%b busy=%b done=%b x=%h w=%h b=%h expected all 0",
               name, mem_rd_en, out_valid, out_first, out_last, busy, done, x_addr, w_addr, b_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    check_all_zero("reset state");
    repeat (2) @(negedge clock_mem);
    check_all_zero("reset held");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_tile(16'h0100, 16'h1000, 16'h2000, 16'd4, 0, 1'b0, "basic");
  endtask

  task automatic test_stall();
    run_tile(16'h0100, 16'h1000, 16'h2000, 16'd4, 2, 1'b0, "stall");
  endtask

  task automatic test_zero_inputs();
    run_tile(16'h0100, 16'h1000, 16'h2000, 16'd0, 0, 1'b0, "zero");
  endtask

  task automatic test_wrap();
    run_tile(16'hFFFE, 16'hFFF0, 16'hFFFB, 16'd3, 0, 1'b0, "wrap");
  endtask

  task automatic test_mid_reset();
    @(negedge clock_mem);
    x_base = 16'h0300; w_base = 16'h4000; b_base = 16'h5000; n_inputs = 16'd6;
    start = 1'b1; acc_ready = 1'b1;
    @(negedge clock_mem);
    start = 1'b0;
    repeat (2) @(negedge clock_mem);
    #1;
    tests_run++;
    if (mem_rd_en !== 1'b1 || x_addr !== 16'h0302) begin
      tests_failed++;
      $display("[TB] FAIL mid-reset setup: got rd=%b x=%h expected rd=1 x=0302", mem_rd_en, x_addr);
    end
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async reset");
    repeat (2) @(negedge clock_mem);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clock_mem);
      #1;
      check_all_zero("after reset");
    end
    run_tile(16'h0300, 16'h4000, 16'h5000, 16'd6, 0, 1'b0, "clean after reset");
  endtask

  task automatic test_start_while_busy();
    run_tile(16'h0A00, 16'h0B00, 16'h0C00, 16'd7, 1, 1'b1, "start while busy");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      run_tile(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom_range(1, 12)),
               1, (t % 2 == 1), "random");
    end
  endtask

  initial begin
    start     = 1'b0;
    acc_ready = 1'b1;
    x_base    = '0;
    w_base    = '0;
    b_base    = '0;
    n_inputs  = '0;
    test_reset();
    test_basic();
    test_stall();
    test_zero_inputs();
    test_wrap();
    test_mid_reset();
    test_start_while_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
